muldivunit: RTL and testbench
=============================

# muldivunit

Iterative multiply/divide unit for the semiMIPS execute stage; it consumes the two ALU operands after operand selection, and owns the architectural HI/LO registers. It implements MULT/MULTU with shift-add and DIV/DIVU with restoring division, one bit per cycle. A start/busy/done handshake lets the pipeline stall while the unit iterates. MTHI/MTLO writes to HI/LO also go through this block.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin operation; sampled only while busy=0.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- opa  input  WIDTH  multiplicand / dividend; sampled with start.
- opb  input  WIDTH  multiplier / divisor; sampled with start.
- hiwe  input  1  MTHI: write wdata into HI; honoured only while busy=0.
- lowe  input  1  MTLO: write wdata into LO; honoured only while busy=0.
- wdata  input  WIDTH  data for hiwe/lowe.
- busy  output  1  high while an operation is in progress; reset 0.
- done  output  1  one-cycle pulse; HI/LO already hold the new result; reset 0.
- divzero  output  1  valid with done; 1 if a divide had opb=0; reset 0.
- hi  output  WIDTH  HI register; reset 0.
- lo  output  WIDTH  LO register; reset 0.

## Operation
- States: IDLE, CALC, FIX. busy = (state != IDLE).
- IDLE with start=1:
  - Latch op.
  - For signed ops, latch the magnitudes |opa| and |opb| and the sign flags. The result is negative if the signs differ; the remainder takes the dividend's sign.
  - Load count = WIDTH-1 and go to CALC.
- CALC, multiply: if multiplier LSB=1, add the multiplicand to the upper half of the 2*WIDTH accumulator (carry kept). Then shift the accumulator right by 1.
- CALC, divide: shift {rem, quo} left by 1. Trial-subtract the divisor from rem. If there is no borrow, keep the difference and set the quotient LSB.
- CALC exits to FIX when count reaches 0 (WIDTH cycles total).
- FIX: apply sign correction, with 2's-complement negation over the full width:
  - Multiply: negate the 64-bit product if negative.
  - Divide: negate the quotient and the remainder per their signs.
- FIX then writes the results: multiply sets HI=product[63:32], LO=product[31:0]; divide sets HI=remainder, LO=quotient. Set done=1 and return to IDLE.
- Divide by zero, either signedness:
  - HI=original opa, LO=all ones, divzero=1 with done.
  - Iteration still runs the full WIDTH cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (falls out of the magnitude path; no special case).
- hiwe/lowe while busy=0: write at the edge.
  - If start is also asserted, the write lands and the operation starts.
  - The operation's result overwrites HI/LO at FIX.
- start, hiwe, lowe while busy=1: ignored. op/opa/opb changes during busy have no effect.

## Timing
- Start sampled at edge E0. busy=1 after E0. CALC occupies edges E1..EWIDTH, FIX is sampled at E(WIDTH+1).
- After E(WIDTH+1): hi/lo are updated, done=1 and busy=0 for exactly one cycle.
- Latency from start to result: WIDTH+1 edges (33 at default).
- A new start is accepted in the same cycle done is high (back-to-back).
- divzero is registered alongside done and clears when done drops.
- rst asserted at any time takes effect immediately, not at a clock edge:
  - state=IDLE, busy=0, done=0, divzero=0, hi=lo=0.
  - Any in-flight operation is abandoned.

## Structure
- Shared package: the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), the state enum (IDLE, CALC, FIX) and the default width constant.
- Single module; the datapath is small enough that no sub-module is warranted. Sign pre/post-processing is inline.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. done exactly 33 edges after the start edge; busy high for 33 cycles.
- MULT 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIVU 100 / 7 back-to-back on the done cycle → LO=14, HI=2.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 → HI=0x12345678, LO=0xFFFFFFFF, divzero=1 for one cycle with done.
- During CALC, pulse start with new operands plus hiwe/lowe (wdata=0xDEADBEEF) → ignored; the original result is written and no second done occurs. While idle, hiwe (wdata=0xDEADBEEF) → hi=0xDEADBEEF next cycle.
- Assert rst mid-edge at CALC cycle 10 → busy, done, hi, lo go to 0 without waiting for a clock. A subsequent start completes normally.

Source files
------------

// File: rtl/muldivunit_pkg.sv
// Shared definitions for the semiMIPS iterative multiply/divide unit:
// op encodings, FSM states and the default operand width.
package muldivunit_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldivunit.sv
// Iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring) unit, one bit per
// cycle, owning the architectural HI/LO registers and the MTHI/MTLO write path.
module muldivunit
  import muldivunit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             hiwe,
  input  logic             lowe,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2 * WIDTH)'(1);

  state_e               state_q;
  op_e                  op_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     opa_q;
  logic [CW-1:0]        count_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 dz_q;
  logic                 done_q;
  logic                 divzero_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  // Operand conditioning at start: magnitudes plus sign flags for signed ops.
  logic             is_signed;
  logic             is_div;
  logic             opa_neg;
  logic             opb_neg;
  logic [WIDTH-1:0] opa_mag;
  logic [WIDTH-1:0] opb_mag;

  assign is_signed = op[0];
  assign is_div    = op[1];
  assign opa_neg   = is_signed & opa[WIDTH-1];
  assign opb_neg   = is_signed & opb[WIDTH-1];
  assign opa_mag   = opa_neg ? (~opa + ONE_W) : opa;
  assign opb_mag   = opb_neg ? (~opb + ONE_W) : opb;

  // One iteration step. The accumulator is {upper, lower}: for multiply the
  // lower half holds the not-yet-consumed multiplier bits; for divide it is
  // {rem, quo}.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_diff;
  logic             div_borrow;

  always_comb begin
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_diff   = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, b_q};
    div_borrow = div_diff[WIDTH+1];
    if (op_q[1]) begin
      acc_d = div_borrow ? {acc_q[2*WIDTH-2:0], 1'b0}
                         : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + ONE_2W) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // sees pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_MULTU;
      acc_q     <= '0;
      b_q       <= '0;
      opa_q     <= '0;
      count_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hiwe) hi_q <= wdata;
          if (lowe) lo_q <= wdata;
          if (start) begin
            op_q      <= op_e'(op);
            acc_q     <= {{WIDTH{1'b0}}, (is_div ? opa_mag : opb_mag)};
            b_q       <= is_div ? opb_mag : opa_mag;
            opa_q     <= opa;
            neg_res_q <= opa_neg ^ opb_neg;
            neg_rem_q <= opa_neg;
            dz_q      <= is_div && (opb == '0);
            count_q   <= CW'(WIDTH - 1);
            state_q   <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (count_q == '0) begin
            state_q <= FIX;
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        FIX: begin
          if (!op_q[1]) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_q <= opa_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q    <= 1'b1;
          divzero_q <= dz_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldivunit.sv
// Self-checking bench for muldivunit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldivunit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        hiwe;
  logic        lowe;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        divzero;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0]  cur_op;
  logic [31:0] cur_a;
  logic [31:0] cur_b;

  muldivunit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .opa     (opa),
    .opb     (opb),
    .hiwe    (hiwe),
    .lowe    (lowe),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .divzero (divzero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of one operation, from plain integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mhi, output logic [31:0] mlo,
                                output logic mdz);
    logic [63:0] up;
    longint      sa, sb, sp;
    mdz = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (o)
      2'b00: begin
        up = {32'b0, a} * {32'b0, b};
        {mhi, mlo} = up;
      end
      2'b01: begin
        sp = sa * sb;
        {mhi, mlo} = sp;
      end
      default: begin
        if (b == 32'd0) begin
          mdz = 1'b1;
          mhi = a;
          mlo = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          mlo = a / b;
          mhi = a % b;
        end else begin
          mlo = 32'(sa / sb);
          mhi = 32'(sa % sb);
        end
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation for one edge; returns #1 after that edge (E0).
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    step();
    start = 1'b0;
    hiwe  = 1'b0;
    lowe  = 1'b0;
    op    = 2'($urandom);
    opa   = $urandom;
    opb   = $urandom;
    cur_op = o;
    cur_a  = a;
    cur_b  = b;
  endtask

  // Steps until done (bounded); lat counts edges since the start edge.
  task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
    lat      = lat0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      step();
      lat++;
    end
    check("done_seen", {63'b0, done}, 64'd1);
  endtask

  task automatic check_result(input string tag);
    logic [31:0] ehi, elo;
    logic        edz;
    model(cur_op, cur_a, cur_b, ehi, elo, edz);
    check({tag, ".hi"}, {32'b0, hi}, {32'b0, ehi});
    check({tag, ".lo"}, {32'b0, lo}, {32'b0, elo});
    check({tag, ".divzero"}, {63'b0, divzero}, {63'b0, edz});
    check({tag, ".busy_at_done"}, {63'b0, busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, bcnt, dones;
    logic [31:0] prev_lo;

    rst = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    hiwe = 1'b0; lowe = 1'b0; wdata = '0;
    #17 rst = 1'b0;
    step();
    check("reset.busy", {63'b0, busy}, 64'd0);
    check("reset.done", {63'b0, done}, 64'd0);
    check("reset.divzero", {63'b0, divzero}, 64'd0);
    check("reset.hilo", {hi, lo}, 64'd0);

    // MULTU max x max with latency and busy-length checks.
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, lat, bcnt);
    check("multu.latency", 64'(lat), 64'd33);
    check("multu.busy_cycles", 64'(bcnt), 64'd33);
    check("multu.hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check_result("multu");
    step();
    check("multu.done_pulse", {63'b0, done}, 64'd0);

    // MULT -3 x 5, then DIVU 100/7 started on the done cycle.
    start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
    wait_done(0, lat, bcnt);
    check("mult.hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check_result("mult");
    start_op(2'b10, 32'd100, 32'd7);
    wait_done(0, lat, bcnt);
    check("divu.b2b_latency", 64'(lat), 64'd33);
    check("divu.hilo", {hi, lo}, {32'd2, 32'd14});
    check_result("divu");

    // Signed divide and the overflow corner, back to back.
    start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, lat, bcnt);
    check("div.hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check_result("div");
    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, lat, bcnt);
    check("div_ovf.hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    check_result("div_ovf");
    step();

    // Divide by zero.
    start_op(2'b10, 32'h1234_5678, 32'd0);
    wait_done(0, lat, bcnt);
    check("divz.latency", 64'(lat), 64'd33);
    check("divz.hilo", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    check("divz.flag", {63'b0, divzero}, 64'd1);
    check_result("divz");
    step();
    check("divz.flag_clear", {63'b0, divzero}, 64'd0);
    check("divz.done_clear", {63'b0, done}, 64'd0);

    // start/hiwe/lowe pulsed mid-CALC must be ignored.
    start_op(2'b00, 32'h0001_2345, 32'h0006_789A);
    repeat (5) step();
    start = 1'b1; op = 2'b11; opa = 32'd9; opb = 32'd3;
    hiwe = 1'b1; lowe = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    start = 1'b0; hiwe = 1'b0; lowe = 1'b0;
    wait_done(6, lat, bcnt);
    check("ignore.latency", 64'(lat), 64'd33);
    check_result("ignore");
    dones = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) dones++;
    end
    check("ignore.no_second_done", 64'(dones), 64'd0);

    // MTHI while idle.
    prev_lo = lo;
    hiwe = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    hiwe = 1'b0;
    check("mthi.hi", {32'b0, hi}, 64'h0000_0000_DEAD_BEEF);
    check("mthi.lo_kept", {32'b0, lo}, {32'b0, prev_lo});
    lowe = 1'b1; wdata = 32'h0BAD_F00D;
    step();
    lowe = 1'b0;
    check("mtlo.lo", {32'b0, lo}, 64'h0000_0000_0BAD_F00D);

    // Asynchronous reset mid-CALC, then a normal operation.
    start_op(2'b01, 32'h0000_1234, 32'hFFFF_0001);
    repeat (10) step();
    #3 rst = 1'b1;
    #1;
    check("arst.busy", {63'b0, busy}, 64'd0);
    check("arst.done", {63'b0, done}, 64'd0);
    check("arst.hilo", {hi, lo}, 64'd0);
    #1 rst = 1'b0;
    step();
    start_op(2'b11, 32'hFFFF_FF00, 32'd7);
    wait_done(0, lat, bcnt);
    check("arst.after_latency", 64'(lat), 64'd33);
    check_result("arst.after");
    step();

    // Randomized operations, sometimes chained on done, sometimes with a
    // concurrent MTHI/MTLO that the result must overwrite.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = pick();
      rb = pick();
      hiwe  = 1'($urandom);
      lowe  = 1'($urandom);
      wdata = $urandom;
      start_op(ro, ra, rb);
      wait_done(0, lat, bcnt);
      check($sformatf("rand%0d.latency", n), 64'(lat), 64'd33);
      check_result($sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 0) begin
        step();
        check($sformatf("rand%0d.done_pulse", n), {63'b0, done}, 64'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
